nv_mac_accum: RTL and testbench
===============================

Name: nv_mac_accum

Overview:
- Sequential stage directly downstream of the 8x8 signed approximate multiplier array.
- Consumes one 16-bit signed product per beat and accumulates a group of ACC_LEN products, or fewer if in_last closes the group early, into a 24-bit dot-product result.
- Presents each result on a registered valid/ready output toward the accumulation/output buffer.
- Sanitises the multiplier's output encoding before accumulation.

Parameters:
- ACC_LEN, 16, default number of products per group; legal range 1..256.
- IN_W, 16, product width; fixed to the multiplier output width.
- ACC_W, 24, accumulator and result width; exact, with no overflow possible, for ACC_LEN≤256.

Ports:
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  16  product, two's complement.
- in_last  in  1  beat closes the group early.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  24  signed group sum.
- out_cnt  out  9  number of products in the group (1..256).
- clr  in  1  synchronous abort of the partial group.

Behaviour:
- Reset: the following are 0 while reset is asserted and on release:
  - out_valid, out_data, out_cnt
  - accumulator, beat counter
  - state = ACCUM
- Reset is asynchronous; it may arrive mid-group and discards all partial state.
- Beat accepted when in_valid && in_ready.
- Input sanitise: in_data==16'h8000 is treated as 0.
  - The upstream stage emits this code for zero-magnitude products with a negative sign.
  - All other codes are sign-extended to ACC_W.
- Group completes on an accepted beat if either holds:
  - in_last=1, or
  - beat counter == ACC_LEN-1.
- On completion, in the same edge:
  - out_data <= acc + sanitised beat
  - out_cnt <= counter + 1
  - out_valid <= 1
  - accumulator and counter <= 0
- Latency: one cycle from the completing beat to out_valid.
- Non-completing beat: acc += beat, counter += 1; out registers are untouched.
- Output hold: out_valid, out_data and out_cnt remain stable until out_valid && out_ready; out_valid then clears at the next edge unless a new completion loads it at the same edge.
- Result and accumulation overlap: beats of the next group are accepted while a prior result waits.
- in_ready = !(out_valid && !out_ready && completing_beat_pending).
  - completing_beat_pending = (counter==ACC_LEN-1) || in_last.
  - in_ready therefore drops only when the current beat would complete a group while the result register is occupied and not draining.
  - in_ready depends combinationally on in_last; the upstream stage must hold in_last stable while in_valid=1.
- Simultaneous out handshake and new completion: the new result loads and out_valid stays 1 with no bubble; full throughput is one result per cycle when ACC_LEN=1.
- clr=1:
  - accumulator and counter <= 0; any beat in that cycle is dropped; in_ready=0 during clr.
  - A pending output result is unaffected.
- States:
  - ACCUM: normal operation.
  - HOLD: out_valid=1 and a completing beat is stalled; in_ready=0.
  - HOLD -> ACCUM when out_ready=1.
  - The state is derivable from the registers; the FSM may be implicit.
- Width: the accumulator never saturates within the legal ACC_LEN range.
- out_cnt is 9 bits, so that 256 is representable.

Decomposition:
- Shared package nv_mac_pkg holds:
  - IN_W, ACC_W
  - NEG_ZERO_CODE = 16'h8000
  - CNT_W = 9
- One natural sub-module, nv_mac_sanitize: combinational sanitise plus sign-extension of in_data.
- Counter, accumulator and output register stay in the top module.

Test Plan:
- ACC_LEN=4; beats 0x0010 ×4, out_ready=1 → one cycle after the 4th beat: out_data=64, out_cnt=4, out_valid for 1 cycle.
- Beats 0x0100, 0xFF00, 0x8000, 0x0005 → out_data=5; 0x8000 contributes 0.
- ACC_LEN=4; beats 0x4000 ×3 with in_last on the 3rd → out_data=49152, out_cnt=3; the next group starts at count 0.
- ACC_LEN=2, out_ready=0: the 1st result is held, the 3rd beat is accepted, and in_ready=0 on the 4th beat. Raise out_ready → the 1st result drains, the 4th beat is accepted next cycle, and the 2nd result appears with no lost or duplicated beat.
- ACC_LEN=256; all beats 0x4000 (16384) → out_data=4194304 (24'h400000), out_cnt=256.
- Reset and clear:
  - Assert nvdla_core_rst after 2 of 4 beats → outputs 0 immediately.
  - A fresh group of 4×0x0001 then gives 4.
  - clr mid-group likewise discards partial sums while a pending result stays valid.

Source files
------------

// File: rtl/nv_mac_pkg.sv
// Shared widths, codes and types for the MAC accumulation stage.
package nv_mac_pkg;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned CNT_W = 9;

  // Multiplier emits this code for a zero-magnitude product with negative sign.
  localparam logic [IN_W-1:0] NEG_ZERO_CODE = 16'h8000;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } mac_state_t;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] cnt;
  } mac_result_t;

endpackage

// File: rtl/nv_mac_sanitize.sv
// Maps the multiplier's negative-zero code to 0 and sign-extends the product.
module nv_mac_sanitize
  import nv_mac_pkg::*;
(
  input  logic [IN_W-1:0]  i_data,
  output logic [ACC_W-1:0] o_data_c
);

  always_comb begin
    o_data_c = '0;
    if (i_data != NEG_ZERO_CODE) begin
      o_data_c = {{(ACC_W-IN_W){i_data[IN_W-1]}}, i_data};
    end
  end

endmodule

// File: rtl/nv_mac_accum.sv
// Accumulates groups of signed products into a 24-bit dot product and
// presents each result on a registered valid/ready output.
module nv_mac_accum
  import nv_mac_pkg::*;
#(
  parameter int unsigned ACC_LEN = 16
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  input  logic             clr
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ACC_LEN - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  mac_result_t      r_result;

  logic [ACC_W-1:0] w_beat;
  logic             w_pending;
  logic             w_drain;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_complete;
  mac_state_t       w_state;

  nv_mac_sanitize u_sanitize (
    .i_data   (in_data),
    .o_data_c (w_beat)
  );

  // State is implied by the output register: HOLD only while a completing
  // beat would have to overwrite a result the consumer has not taken.
  always_comb begin
    w_pending  = (r_cnt == LAST_IDX) || in_last;
    w_drain    = r_out_valid && out_ready;
    w_state    = ST_ACCUM;
    if (r_out_valid && !out_ready && w_pending) begin
      w_state = ST_HOLD;
    end
    w_in_ready = (w_state == ST_ACCUM) && !clr;
    w_accept   = in_valid && w_in_ready;
    w_complete = w_accept && w_pending;
  end

  // Partial group: cleared by abort or by completion, otherwise accumulates.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clr || w_complete) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= r_acc + w_beat;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result register: a new completion wins over a same-edge drain.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else if (w_complete) begin
      r_out_valid   <= 1'b1;
      r_result.data <= r_acc + w_beat;
      r_result.cnt  <= r_cnt + CNT_W'(1);
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_result.data;
  assign out_cnt   = r_result.cnt;

endmodule

// File: tb/tb_nv_mac_accum.sv
// Bench for nv_mac_accum: three instances (ACC_LEN 4, 2, 256) against a group-sum model.
module tb_nv_mac_accum;

  localparam int ND = 3;

  logic                 clk;
  logic                 rst;
  logic [ND-1:0]        in_valid;
  logic [ND-1:0]        in_last;
  logic [ND-1:0]        out_ready;
  logic [ND-1:0]        clr;
  logic [ND-1:0][15:0]  in_data;
  logic [ND-1:0]        in_ready;
  logic [ND-1:0]        out_valid;
  logic [ND-1:0][23:0]  out_data;
  logic [ND-1:0][8:0]   out_cnt;

  int n_vec;
  int n_bad;

  // Model: products in the open group, and the result slot.
  int m_len [ND];
  int m_sum [ND];
  int m_ov  [ND];
  int m_od  [ND];
  int m_oc  [ND];

  typedef struct {
    int          d;
    bit          v;
    logic [15:0] x;
    bit          last;
    bit          ordy;
    bit          c;
    bit          chk;
    int          ev;
    int          ed;
    int          ec;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 4 : ((g == 1) ? 2 : 256);
    nv_mac_accum #(.ACC_LEN(L)) u_dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .in_valid       (in_valid[g]),
      .in_ready       (in_ready[g]),
      .in_data        (in_data[g]),
      .in_last        (in_last[g]),
      .out_valid      (out_valid[g]),
      .out_ready      (out_ready[g]),
      .out_data       (out_data[g]),
      .out_cnt        (out_cnt[g]),
      .clr            (clr[g])
    );
  end

  function automatic int acc_len(int d);
    case (d)
      0:       return 4;
      1:       return 2;
      default: return 256;
    endcase
  endfunction

  function automatic int sanit(logic [15:0] x);
    if (x == 16'h8000) return 0;
    return int'($signed(x));
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(int d, string tag, int ev, int ed, int ec);
    check($sformatf("%s.valid[%0d]", tag, d), int'(out_valid[d]), ev);
    check($sformatf("%s.data[%0d]", tag, d), int'($signed(out_data[d])), ed);
    check($sformatf("%s.cnt[%0d]", tag, d), int'(out_cnt[d]), ec);
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_len[d] = 0; m_sum[d] = 0; m_ov[d] = 0; m_od[d] = 0; m_oc[d] = 0;
    end
  endtask

  task automatic set_idle();
    in_valid = '0;
    in_last  = '0;
    clr      = '0;
    in_data  = '0;
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    int rdy [ND];
    #1;
    for (int d = 0; d < ND; d++) begin
      bit pend;
      pend = (m_len[d] == acc_len(d) - 1) || (in_last[d] == 1'b1);
      rdy[d] = (clr[d] == 1'b0 && !(m_ov[d] == 1 && out_ready[d] == 1'b0 && pend)) ? 1 : 0;
      check($sformatf("in_ready[%0d]", d), int'(in_ready[d]), rdy[d]);
    end
    for (int d = 0; d < ND; d++) begin
      bit pend;
      bit acc;
      int x;
      pend = (m_len[d] == acc_len(d) - 1) || (in_last[d] == 1'b1);
      acc  = (in_valid[d] == 1'b1) && (rdy[d] == 1);
      x    = sanit(in_data[d]);
      if (acc && pend) begin
        m_ov[d] = 1;
        m_od[d] = m_sum[d] + x;
        m_oc[d] = m_len[d] + 1;
      end else if (m_ov[d] == 1 && out_ready[d] == 1'b1) begin
        m_ov[d] = 0;
      end
      if (clr[d] == 1'b1 || (acc && pend)) begin
        m_len[d] = 0;
        m_sum[d] = 0;
      end else if (acc) begin
        m_len[d] = m_len[d] + 1;
        m_sum[d] = m_sum[d] + x;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) expect_out(d, "model", m_ov[d], m_od[d], m_oc[d]);
  endtask

  task automatic drive(int d, bit v, logic [15:0] x, bit last, bit ordy, bit c);
    set_idle();
    in_valid[d]  = v;
    in_data[d]   = x;
    in_last[d]   = last;
    out_ready[d] = ordy;
    clr[d]       = c;
    cycle();
  endtask

  task automatic add(int d, bit v, logic [15:0] x, bit last, bit ordy, bit c,
                     bit chk, int ev, int ed, int ec);
    vec_t t;
    t.d = d; t.v = v; t.x = x; t.last = last; t.ordy = ordy; t.c = c;
    t.chk = chk; t.ev = ev; t.ed = ed; t.ec = ec;
    tbl.push_back(t);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    set_idle();
    out_ready = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) expect_out(d, "in_reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ACC_LEN=4 directed groups: full group, neg-zero code, early in_last.
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0010, 0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 16'h0010, 0, 1, 0, 1, 1, 64, 4);
    add(0, 0, 16'h0000, 0, 1, 0, 1, 0, 64, 4);
    add(0, 1, 16'h0100, 0, 1, 0, 1, 0, 64, 4);
    add(0, 1, 16'hFF00, 0, 1, 0, 1, 0, 64, 4);
    add(0, 1, 16'h8000, 0, 1, 0, 1, 0, 64, 4);
    add(0, 1, 16'h0005, 0, 1, 0, 1, 1, 5, 4);
    add(0, 1, 16'h4000, 0, 1, 0, 1, 0, 5, 4);
    add(0, 1, 16'h4000, 0, 1, 0, 1, 0, 5, 4);
    add(0, 1, 16'h4000, 1, 1, 0, 1, 1, 49152, 3);
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0001, 0, 1, 0, 1, 0, 49152, 3);
    add(0, 1, 16'h0001, 0, 1, 0, 1, 1, 4, 4);
    add(0, 0, 16'h0000, 0, 1, 0, 1, 0, 4, 4);
    foreach (tbl[i]) begin
      drive(tbl[i].d, tbl[i].v, tbl[i].x, tbl[i].last, tbl[i].ordy, tbl[i].c);
      if (tbl[i].chk) expect_out(tbl[i].d, $sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec);
    end

    // ACC_LEN=2 backpressure: held result, overlap beat, stall, drain+load.
    drive(1, 1, 16'h0001, 0, 0, 0);
    drive(1, 1, 16'h0002, 0, 0, 0);
    expect_out(1, "bp_first", 1, 3, 2);
    drive(1, 1, 16'h0004, 0, 0, 0);
    expect_out(1, "bp_overlap", 1, 3, 2);
    drive(1, 1, 16'h0008, 0, 0, 0);
    check("bp_stall_ready", int'(in_ready[1]), 0);
    expect_out(1, "bp_stall", 1, 3, 2);
    drive(1, 1, 16'h0008, 0, 1, 0);
    expect_out(1, "bp_second", 1, 12, 2);
    drive(1, 0, 16'h0000, 0, 1, 0);
    expect_out(1, "bp_drained", 0, 12, 2);

    // ACC_LEN=256 worst-case positive group.
    for (int i = 0; i < 256; i++) drive(2, 1, 16'h4000, 0, 1, 0);
    expect_out(2, "len256", 1, 4194304, 256);
    drive(2, 0, 16'h0000, 0, 1, 0);

    // Asynchronous reset in the middle of a group.
    drive(0, 1, 16'h0001, 0, 1, 0);
    drive(0, 1, 16'h0001, 0, 1, 0);
    set_idle();
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) expect_out(d, "async_rst", 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) drive(0, 1, 16'h0001, 0, 1, 0);
    expect_out(0, "after_rst", 1, 4, 4);
    drive(0, 0, 16'h0000, 0, 1, 0);

    // clr mid-group while a result is pending.
    for (int i = 0; i < 4; i++) drive(0, 1, 16'h0002, 0, 0, 0);
    expect_out(0, "clr_pending", 1, 8, 4);
    drive(0, 1, 16'h0003, 0, 0, 0);
    drive(0, 1, 16'h0003, 0, 0, 0);
    drive(0, 1, 16'h0100, 0, 0, 1);
    check("clr_ready", int'(in_ready[0]), 0);
    expect_out(0, "clr_hold", 1, 8, 4);
    drive(0, 0, 16'h0000, 0, 1, 0);
    expect_out(0, "clr_drain", 0, 8, 4);
    for (int i = 0; i < 4; i++) drive(0, 1, 16'h0001, 0, 1, 0);
    expect_out(0, "after_clr", 1, 4, 4);

    // Randomized traffic on all instances.
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < ND; d++) begin
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(7) == 0) r = 16'h8000;
        in_valid[d]  = ($urandom_range(3) != 0);
        in_data[d]   = r;
        in_last[d]   = ($urandom_range(7) == 0);
        out_ready[d] = ($urandom_range(2) != 0);
        clr[d]       = ($urandom_range(31) == 0);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
